// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request/response pair.
// Each access runs IDLE -> WAIT (WAIT_CYC+1 cycles) -> RESP; faults are counted and never write.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYC    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  err_cnt
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic          fault;
  logic          commit;
  logic          we;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   rd_word;
  logic [31:0]   load_data;

  assign idx   = addr_q[AW+1:2];
  assign fault = (size_q == 2'b11)
               | ((size_q == 2'b01) & addr_q[0])
               | ((size_q == 2'b10) & (addr_q[1:0] != 2'b00))
               | (32'(addr_q[15:2]) >= DEPTH_WORDS);

  // Byte-lane steering for stores and right-alignment for loads.
  always_comb begin
    be        = 4'b0000;
    wlane     = wdata_q;
    rd_word   = mem_q[idx];
    load_data = rd_word;
    case (size_q)
      2'b00: begin
        be        = 4'b0001 << addr_q[1:0];
        wlane     = {4{wdata_q[7:0]}};
        load_data = {24'b0, rd_word[{addr_q[1:0], 3'b000} +: 8]};
      end
      2'b01: begin
        be        = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane     = {2{wdata_q[15:0]}};
        load_data = addr_q[1] ? {16'b0, rd_word[31:16]} : {16'b0, rd_word[15:0]};
      end
      default: begin
        be        = 4'b1111;
        wlane     = wdata_q;
        load_data = rd_word;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    commit    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          wr_d    = req_wr;
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(WAIT_CYC);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = StResp;
          err_d   = fault;
          rdata_d = (fault || wr_q) ? 32'b0 : load_data;
          if (fault && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign we        = commit & wr_q & ~fault;
  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign err_cnt   = err_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      wr_q      <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= 16'h0000;
      wdata_q   <= 32'h0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[idx][8*i +: 8] <= wlane[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: two instances (WAIT_CYC=1 and 3) on a shared request bus,
// expected responses queued at issue time and compared when the response appears.
module tb_mem_responder;

  logic        clk;
  logic        rst1, rst3;
  logic        use3;
  logic        req_valid, req_wr, rsp_ready;
  logic [1:0]  req_size;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;

  logic        req_ready1, req_ready3, rsp_valid1, rsp_valid3, rsp_err1, rsp_err3;
  logic [31:0] rsp_rdata1, rsp_rdata3;
  logic [7:0]  err_cnt1, err_cnt3;

  logic        m_req_ready, m_rsp_valid, m_rsp_err;
  logic [31:0] m_rsp_rdata;
  logic [7:0]  m_err_cnt;

  assign m_req_ready = use3 ? req_ready3 : req_ready1;
  assign m_rsp_valid = use3 ? rsp_valid3 : rsp_valid1;
  assign m_rsp_err   = use3 ? rsp_err3   : rsp_err1;
  assign m_rsp_rdata = use3 ? rsp_rdata3 : rsp_rdata1;
  assign m_err_cnt   = use3 ? err_cnt3   : err_cnt1;

  mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYC(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst1),
    .req_valid (req_valid & ~use3),
    .req_ready (req_ready1),
    .req_wr    (req_wr),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid1),
    .rsp_ready (rsp_ready & ~use3),
    .rsp_rdata (rsp_rdata1),
    .rsp_err   (rsp_err1),
    .err_cnt   (err_cnt1)
  );

  mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYC(3)) u_dut3 (
    .clk       (clk),
    .rst       (rst3),
    .req_valid (req_valid & use3),
    .req_ready (req_ready3),
    .req_wr    (req_wr),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid3),
    .rsp_ready (rsp_ready & use3),
    .rsp_rdata (rsp_rdata3),
    .rsp_err   (rsp_err3),
    .err_cnt   (err_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request, wait for its acceptance edge, then scramble the bus.
  task automatic issue(input logic wr, input logic [1:0] size, input logic [15:0] addr,
                       input logic [31:0] wdata, input logic [31:0] er, input logic ee);
    exp_t e;
    int   n;
    e.rdata = er;
    e.err   = ee;
    sb.push_back(e);
    @(negedge clk);
    req_wr    = wr;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    while (!m_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_at_issue", {31'b0, m_req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wr    = ~wr;
    req_size  = 2'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = $urandom;
  endtask

  // Wait for the response, check latency and data, optionally stall, then handshake.
  task automatic finish_rsp(input int bp);
    int          lat;
    exp_t        e;
    logic [31:0] held;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!m_rsp_valid && lat < 40);
    chk("rsp_latency", 32'(lat), use3 ? 32'd5 : 32'd3);
    chk("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rsp_rdata", m_rsp_rdata, e.rdata);
      chk("rsp_err", {31'b0, m_rsp_err}, {31'b0, e.err});
    end
    held = m_rsp_rdata;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {31'b0, m_rsp_valid}, 32'd1);
      chk("bp_rsp_rdata", m_rsp_rdata, held);
      chk("bp_req_ready", {31'b0, m_req_ready}, 32'd0);
    end
    chk("req_ready_in_resp", {31'b0, m_req_ready}, 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("req_ready_after_hs", {31'b0, m_req_ready}, 32'd1);
    chk("rsp_valid_after_hs", {31'b0, m_rsp_valid}, 32'd0);
  endtask

  task automatic xact(input logic wr, input logic [1:0] size, input logic [15:0] addr,
                      input logic [31:0] wdata, input logic [31:0] er, input logic ee);
    issue(wr, size, addr, wdata, er, ee);
    finish_rsp(0);
  endtask

  initial begin
    int lat;
    rst1 = 1'b0; rst3 = 1'b0; use3 = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; rsp_ready = 1'b0;
    req_size = 2'b00; req_addr = 16'h0; req_wdata = 32'h0;

    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", {31'b0, m_rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", m_rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'b0, m_rsp_err}, 32'd0);
    chk("rst_err_cnt", {24'b0, m_err_cnt}, 32'd0);
    rst1 = 1'b1;
    rst3 = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, m_req_ready}, 32'd1);

    // Word store then load
    xact(1'b1, 2'b10, 16'h0010, 32'hDEADBEEF, 32'h0, 1'b0);
    xact(1'b0, 2'b10, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0);
    xact(1'b1, 2'b01, 16'h0012, 32'h1234CAFE, 32'h0, 1'b0);
    xact(1'b0, 2'b10, 16'h0010, 32'h0, 32'hCAFEBEEF, 1'b0);

    // Byte lanes
    xact(1'b1, 2'b10, 16'h0020, 32'h11223344, 32'h0, 1'b0);
    xact(1'b1, 2'b00, 16'h0022, 32'h000000AA, 32'h0, 1'b0);
    xact(1'b0, 2'b10, 16'h0020, 32'h0, 32'h11AA3344, 1'b0);
    xact(1'b0, 2'b01, 16'h0022, 32'h0, 32'h000011AA, 1'b0);
    xact(1'b0, 2'b00, 16'h0021, 32'h0, 32'h00000033, 1'b0);
    xact(1'b1, 2'b10, 16'h0000, 32'h01020304, 32'h0, 1'b0);

    // Faults; stores among them must not land (0x1000 aliases word 0 if unguarded)
    xact(1'b0, 2'b10, 16'h0021, 32'h0, 32'h0, 1'b1);
    xact(1'b0, 2'b01, 16'h0003, 32'h0, 32'h0, 1'b1);
    xact(1'b1, 2'b11, 16'h0020, 32'hFFFFFFFF, 32'h0, 1'b1);
    xact(1'b1, 2'b10, 16'h1000, 32'h0BADF00D, 32'h0, 1'b1);
    @(negedge clk);
    chk("err_cnt_4", {24'b0, m_err_cnt}, 32'd4);
    xact(1'b0, 2'b10, 16'h0020, 32'h0, 32'h11AA3344, 1'b0);
    xact(1'b0, 2'b10, 16'h0000, 32'h0, 32'h01020304, 1'b0);

    // Backpressure
    issue(1'b0, 2'b10, 16'h0020, 32'h0, 32'h11AA3344, 1'b0);
    finish_rsp(5);

    // Saturation
    for (int i = 0; i < 251; i++) xact(1'b0, 2'b11, 16'h0000, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("err_cnt_255", {24'b0, m_err_cnt}, 32'd255);
    for (int i = 0; i < 9; i++) xact(1'b0, 2'b10, 16'h0002, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("err_cnt_sat", {24'b0, m_err_cnt}, 32'd255);

    // Reset during WAIT on the WAIT_CYC=3 instance
    use3 = 1'b1;
    xact(1'b1, 2'b00, 16'h0030, 32'h00000012, 32'h0, 1'b0);
    issue(1'b1, 2'b00, 16'h0030, 32'h00000055, 32'h0, 1'b0);
    @(posedge clk);
    #2;
    rst3 = 1'b0;
    #1;
    sb.delete();
    chk("abort_rsp_valid", {31'b0, m_rsp_valid}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_rsp_valid_rst", {31'b0, m_rsp_valid}, 32'd0);
    end
    rst3 = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("abort_rsp_valid_post", {31'b0, m_rsp_valid}, 32'd0);
      chk("abort_req_ready_post", {31'b0, m_req_ready}, 32'd1);
    end
    xact(1'b0, 2'b00, 16'h0030, 32'h0, 32'h00000012, 1'b0);

    // Reset while holding a response
    issue(1'b0, 2'b00, 16'h0030, 32'h0, 32'h00000012, 1'b0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!m_rsp_valid && lat < 40);
    chk("resp_rst_latency", 32'(lat), 32'd5);
    #2;
    rst3 = 1'b0;
    #1;
    sb.delete();
    chk("resp_rst_valid", {31'b0, m_rsp_valid}, 32'd0);
    chk("resp_rst_rdata", m_rsp_rdata, 32'h0);
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    chk("resp_rst_req_ready", {31'b0, m_req_ready}, 32'd1);
    xact(1'b0, 2'b00, 16'h0030, 32'h0, 32'h00000012, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words in the storage array.
REQ-002 SHALL have parameter WAIT_CYC, default 1, added wait states per access, legal range 0..15.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset that is asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1 bit, core presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit, responder can accept a request.
REQ-007 SHALL have port req_wr, input, 1 bit, 1 = store, 0 = load.
REQ-008 SHALL have port req_size, input, 2 bits, access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 SHALL have port req_addr, input, 16 bits, byte address.
REQ-010 SHALL have port req_wdata, input, 32 bits, store data, right-aligned.
REQ-011 SHALL have port rsp_valid, output, 1 bit, response available.
REQ-012 SHALL have port rsp_ready, input, 1 bit, core accepts the response.
REQ-013 SHALL have port rsp_rdata, output, 32 bits, load data, right-aligned, zero-extended.
REQ-014 SHALL have port rsp_err, output, 1 bit, access faulted.
REQ-015 SHALL have port err_cnt, output, 8 bits, count of faulted accesses, saturating.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; a request is accepted on an edge where req_valid=1 and req_ready=1.
REQ-018 SHALL latch req_wr, req_size, req_addr and req_wdata on acceptance; later changes to the inputs SHALL have no effect.
REQ-019 On acceptance SHALL go to WAIT with a wait counter loaded to WAIT_CYC; WAIT SHALL decrement the counter each cycle and go to RESP on the edge where the counter is 0.
REQ-020 With WAIT_CYC=0, WAIT SHALL last exactly one cycle, so rsp_valid rises on the second edge after acceptance; generally rsp_valid rises WAIT_CYC+2 edges after the acceptance edge.
REQ-021 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until an edge where rsp_ready=1, then go to IDLE.
REQ-022 SHALL NOT accept a request in the cycle in which a response handshake occurs; req_ready rises the following cycle.
REQ-023 Fault conditions: req_size=11; halfword with addr[0]=1; word with addr[1:0]!=00; word index addr[15:2] >= DEPTH_WORDS.
REQ-024 On a fault SHALL set rsp_err=1 and rsp_rdata=0, suppress any storage write, and increment err_cnt unless it is at 255.
REQ-025 Stores SHALL be little-endian byte-lane writes.
- Byte: lane addr[1:0] gets wdata[7:0].
- Halfword: lanes {addr[1],0} and {addr[1],1} get wdata[15:0].
- Word: all four lanes.
- Unselected lanes SHALL be unchanged.
REQ-026 Store commit SHALL occur on the WAIT-to-RESP edge; stores SHALL return rsp_rdata=0.
REQ-027 Loads SHALL sample storage on the WAIT-to-RESP edge and return the selected lanes right-aligned, with upper bits zero.
REQ-028 A load following a store to the same address SHALL return the newly stored data.
REQ-029 The storage array SHALL NOT be reset; its contents are undefined until written.

Reset
REQ-030 Reset asserted (rst=0) SHALL immediately force state=IDLE, req_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_err=0, err_cnt=0 and wait counter=0.
REQ-031 Reset in WAIT before the commit edge SHALL abort the access, with no storage write and no response.
REQ-032 Reset in RESP SHALL drop rsp_valid asynchronously; the response is lost.

Verification
REQ-033 Word store then load, WAIT_CYC=1:
- Stimulus: store addr=0x0010, wdata=0xDEADBEEF, then load addr=0x0010.
- Required: rsp_valid rises 3 edges after each acceptance; the load returns 0xDEADBEEF with rsp_err=0.
REQ-034 Byte lanes:
- Stimulus: store word 0x11223344 at 0x0020, then byte 0xAA at 0x0022, then load word 0x0020, then load halfword 0x0022.
- Required: the word load returns 0x11AA3344; the halfword load returns 0x000011AA.
REQ-035 Faults:
- Stimulus: load word at 0x0021, then halfword at 0x0003, then size=11, then word at 0x1000 with DEPTH_WORDS=1024.
- Required: each returns rsp_err=1 and rdata=0; err_cnt=4; the contents of 0x0020 are unchanged.
REQ-036 Backpressure:
- Stimulus: hold rsp_ready=0 for 5 cycles in RESP.
- Required: rsp_valid and rsp_rdata are stable for the whole interval; req_ready=0 for the whole interval; req_ready=1 the cycle after the rsp_ready=1 edge.
REQ-037 Reset mid-access:
- Stimulus: start store 0x55 to byte 0x0030 with WAIT_CYC=3; assert rst=0 in the 2nd WAIT cycle.
- Required: rsp_valid stays 0; after release, a load of byte 0x0030 returns its prior value.
REQ-038 Saturation:
- Stimulus: issue 260 faulted accesses.
- Required: err_cnt=255 and stays there.
